// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the architectural PC, runs the instruction-memory
// request/ack handshake and presents one held instruction at a time to decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        id_ready
);

  typedef enum logic [2:0] {BOOT, FETCH, HOLD, DRAIN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, addr_n, inst_n, ifpc_n;
  logic        req_n, valid_n;
  logic [31:0] tgt, seq_pc;

  assign tgt    = {redirect_target[31:2], 2'b00};
  assign seq_pc = if_pc + 32'd4;
  assign if_pc4 = if_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
      if_valid  <= 1'b0;
      if_inst   <= 32'd0;
      if_pc     <= 32'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      if_valid  <= valid_n;
      if_inst   <= inst_n;
      if_pc     <= ifpc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = imem_req;
    addr_n  = imem_addr;
    valid_n = if_valid;
    inst_n  = if_inst;
    ifpc_n  = if_pc;
    case (state)
      BOOT: begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = {pc[31:2], 2'b00};
      end
      FETCH: begin
        if (redirect) begin
          pc_n = tgt;
          // Ack in the same cycle frees the port, so re-issue at the target now;
          // otherwise the in-flight request must be drained first.
          if (imem_ack) addr_n  = tgt;
          else          state_n = DRAIN;
        end else if (imem_ack) begin
          inst_n  = imem_rdata;
          ifpc_n  = imem_addr;
          valid_n = 1'b1;
          req_n   = 1'b0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = tgt;
          req_n   = 1'b1;
          addr_n  = tgt;
          state_n = FETCH;
        end else if (id_ready) begin
          valid_n = 1'b0;
          if (halt) begin
            state_n = HALT;
          end else begin
            pc_n    = seq_pc;
            req_n   = 1'b1;
            addr_n  = seq_pc;
            state_n = FETCH;
          end
        end
      end
      DRAIN: begin
        if (redirect) pc_n = tgt;
        if (imem_ack) begin
          // Stale response dropped; a coincident redirect is the newest target.
          addr_n  = redirect ? tgt : pc;
          state_n = FETCH;
        end
      end
      HALT: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
      end
      default: state_n = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one task per scenario, inline checks,
// inputs driven 1 time unit after the rising edge and outputs sampled there too.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        halt = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst, if_pc, if_pc4;
  logic        id_ready = 1'b0;

  int nvec = 0;
  int nerr = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_target = 0;
    halt = 0; id_ready = 0;
  endtask

  // Reset, release, and advance through BOOT so the DUT is in FETCH at RESET_PC.
  task automatic reset_to_fetch();
    clear_inputs();
    rst = 1; tick(); rst = 0; tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    tick();
    rst = 1; #1;
    nvec++; if (imem_req !== 1'b0)   begin nerr++; $display("FAIL rst_req got %0b want 0", imem_req); end
    nvec++; if (imem_addr !== 32'd0) begin nerr++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    nvec++; if (if_valid !== 1'b0)   begin nerr++; $display("FAIL rst_valid got %0b want 0", if_valid); end
    nvec++; if (if_inst !== 32'd0 || if_pc !== 32'd0) begin nerr++; $display("FAIL rst_if got inst=%h pc=%h want 0/0", if_inst, if_pc); end
    nvec++; if (if_pc4 !== 32'd4)    begin nerr++; $display("FAIL rst_pc4 got %h want 4", if_pc4); end
    tick(); rst = 0;
    nvec++; if (imem_req !== 1'b0)   begin nerr++; $display("FAIL boot_req got %0b want 0", imem_req); end
    tick();
    nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin nerr++; $display("FAIL boot_fetch got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    reset_to_fetch();
    id_ready = 1;
    for (int k = 0; k < 4; k++) begin
      a = 32'(k * 4);
      nvec++; if (imem_req !== 1'b1 || imem_addr !== a) begin nerr++; $display("FAIL stream_req%0d got req=%0b addr=%h want 1/%h", k, imem_req, imem_addr, a); end
      imem_ack = 1; imem_rdata = mem(a);
      tick();
      imem_ack = 0;
      nvec++; if (if_valid !== 1'b1 || if_pc !== a || if_inst !== mem(a)) begin nerr++; $display("FAIL stream_out%0d got v=%0b pc=%h inst=%h want 1/%h/%h", k, if_valid, if_pc, if_inst, a, mem(a)); end
      nvec++; if (if_pc4 !== a + 32'd4 || imem_req !== 1'b0) begin nerr++; $display("FAIL stream_pc4_%0d got pc4=%h req=%0b want %h/0", k, if_pc4, imem_req, a + 32'd4); end
      tick();
    end
  endtask

  task automatic test_wait_and_hold();
    reset_to_fetch();
    for (int c = 0; c < 3; c++) begin
      nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || if_valid !== 1'b0) begin nerr++; $display("FAIL wait_c%0d got req=%0b addr=%h v=%0b want 1/0/0", c, imem_req, imem_addr, if_valid); end
      tick();
    end
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 0; imem_rdata = 32'hFFFF_FFFF;
    nvec++; if (if_valid !== 1'b1 || if_inst !== 32'h1234_5678) begin nerr++; $display("FAIL wait_ack got v=%0b inst=%h want 1/12345678", if_valid, if_inst); end
    for (int c = 0; c < 4; c++) begin
      tick();
      nvec++; if (if_valid !== 1'b1 || if_inst !== 32'h1234_5678 || if_pc !== 32'd0 || imem_req !== 1'b0) begin nerr++; $display("FAIL hold_c%0d got v=%0b inst=%h pc=%h req=%0b want 1/12345678/0/0", c, if_valid, if_inst, if_pc, imem_req); end
    end
    id_ready = 1; tick(); id_ready = 0;
    nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'd4 || if_valid !== 1'b0) begin nerr++; $display("FAIL hold_release got req=%0b addr=%h v=%0b want 1/4/0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_drain();
    reset_to_fetch();
    redirect = 1; redirect_target = 32'h100;
    tick();
    redirect = 0;
    nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin nerr++; $display("FAIL drain_keep got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
    tick();
    imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    nvec++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin nerr++; $display("FAIL drain_drop got v=%0b req=%0b addr=%h want 0/1/100", if_valid, imem_req, imem_addr); end
    imem_rdata = mem(32'h100);
    tick();
    imem_ack = 0;
    nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== mem(32'h100)) begin nerr++; $display("FAIL drain_out got v=%0b pc=%h inst=%h want 1/100/%h", if_valid, if_pc, if_inst, mem(32'h100)); end
    // Two redirects while draining: the later target is the one fetched.
    reset_to_fetch();
    redirect = 1; redirect_target = 32'h100; tick();
    redirect_target = 32'h200; tick();
    redirect = 0; imem_ack = 1; tick(); imem_ack = 0;
    nvec++; if (imem_addr !== 32'h200 || if_valid !== 1'b0) begin nerr++; $display("FAIL drain_last got addr=%h v=%0b want 200/0", imem_addr, if_valid); end
  endtask

  task automatic test_redirect_ack();
    reset_to_fetch();
    imem_ack = 1; imem_rdata = 32'hBAD0_0001; redirect = 1; redirect_target = 32'h40;
    tick();
    nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_valid !== 1'b0) begin nerr++; $display("FAIL rack_40 got req=%0b addr=%h v=%0b want 1/40/0", imem_req, imem_addr, if_valid); end
    redirect_target = 32'h43;
    tick();
    nvec++; if (imem_addr !== 32'h40 || if_valid !== 1'b0) begin nerr++; $display("FAIL rack_43 got addr=%h v=%0b want 40/0", imem_addr, if_valid); end
    redirect = 0; imem_rdata = mem(32'h40);
    tick();
    imem_ack = 0;
    nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== mem(32'h40)) begin nerr++; $display("FAIL rack_out got v=%0b pc=%h inst=%h want 1/40/%h", if_valid, if_pc, if_inst, mem(32'h40)); end
    // Redirect beats id_ready in HOLD; wrapping target checks modulo arithmetic.
    redirect = 1; redirect_target = 32'hFFFF_FFFE; id_ready = 1;
    tick();
    redirect = 0; id_ready = 0;
    nvec++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL hold_redir got v=%0b req=%0b addr=%h want 0/1/fffffffc", if_valid, imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0BAD_F00D;
    tick();
    imem_ack = 0;
    nvec++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'd0) begin nerr++; $display("FAIL wrap_pc4 got pc=%h pc4=%h want fffffffc/0", if_pc, if_pc4); end
    id_ready = 1; tick(); id_ready = 0;
    nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin nerr++; $display("FAIL wrap_next got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_halt();
    reset_to_fetch();
    id_ready = 1;
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1; imem_rdata = mem(32'(k * 4));
      tick();
      imem_ack = 0;
      if (k < 2) tick();
    end
    nvec++; if (if_valid !== 1'b1 || if_pc !== 32'd8) begin nerr++; $display("FAIL halt_pre got v=%0b pc=%h want 1/8", if_valid, if_pc); end
    halt = 1;
    tick();
    halt = 0; id_ready = 0;
    nvec++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin nerr++; $display("FAIL halt_enter got req=%0b v=%0b want 0/0", imem_req, if_valid); end
    redirect = 1; redirect_target = 32'h300; imem_ack = 1; id_ready = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin nerr++; $display("FAIL halt_stay%0d got req=%0b v=%0b want 0/0", c, imem_req, if_valid); end
    end
    clear_inputs();
    rst = 1; #1;
    nvec++; if (imem_addr !== 32'd0 || if_pc !== 32'd0) begin nerr++; $display("FAIL halt_rst got addr=%h pc=%h want 0/0", imem_addr, if_pc); end
    tick(); rst = 0; tick();
    nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin nerr++; $display("FAIL halt_restart got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_and_hold();
    test_drain();
    test_redirect_ack();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that owns the architectural PC register and sequences instruction-memory requests around the next-PC logic. Each cycle it decides whether the PC advances by 4, jumps to a resolved branch/jump target, holds for a stalled decode stage, or stops on halt. It also handles the request/acknowledge handshake with instruction memory. It sits between the instruction memory port and the IF/ID boundary and consumes the `npc` and `br` results produced downstream as a single redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  instruction-memory request, registered.
- `imem_addr`  out  32  request address, registered, word-aligned.
- `imem_ack`  in  1  one-cycle acknowledge; valid only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `redirect`  in  1  taken branch/jump resolved this cycle.
- `redirect_target`  in  32  new PC, valid with `redirect`.
- `halt`  in  1  stop fetching after the instruction currently held.
- `if_valid`  out  1  `if_inst`/`if_pc`/`if_pc4` hold a live instruction.
- `if_inst`  out  32  fetched instruction.
- `if_pc`  out  32  address of `if_inst`.
- `if_pc4`  out  32  `if_pc` + 4.
- `id_ready`  in  1  decode consumes the held instruction this cycle.

## Operation
- State register with states BOOT, FETCH, HOLD, DRAIN and HALT. Registers: `pc`, `imem_addr`, `if_inst`, `if_pc`.
- Reset values: state=BOOT, `pc`=RESET_PC, `imem_req`=0, `imem_addr`=0, `if_valid`=0, `if_inst`=0, `if_pc`=0. `if_pc4` is combinational, so it reads 4 during reset.
- BOOT: next state is FETCH, with `imem_req`<=1 and `imem_addr`<=`pc`.
- FETCH (`imem_req`=1, `imem_addr` stable):
  - `imem_ack` and no `redirect`: `if_inst`<=`imem_rdata`, `if_pc`<=`imem_addr`, `if_valid`<=1, `imem_req`<=0, next state HOLD.
  - `redirect` and `imem_ack` in the same cycle: discard the response, `pc`<=target, `imem_addr`<=target, stay in FETCH with the request still asserted.
  - `redirect` without `imem_ack`: `pc`<=target, next state DRAIN. The outstanding request cannot be cancelled, so `imem_addr` keeps the old address.
- HOLD (`if_valid`=1, `imem_req`=0):
  - `redirect` has priority over `id_ready`: `if_valid`<=0, `pc`<=target, start a request at target, next state FETCH.
  - `id_ready` without `halt`: `if_valid`<=0, `pc`<=`if_pc`+4, start a request at that address, next state FETCH.
  - `id_ready` with `halt`: `if_valid`<=0, next state HALT.
  - Otherwise hold every output unchanged.
- DRAIN (`imem_req`=1, old address):
  - `imem_ack`: drop `imem_rdata`, `imem_addr`<=`pc`, next state FETCH.
  - A further `redirect` overwrites `pc` (the last one wins); the state stays DRAIN unless `imem_ack` arrives in the same cycle.
- HALT: `imem_req`=0 and `if_valid`=0. Only `rst` leaves this state; `redirect` is ignored.
- Arithmetic: all PC sums are 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 = 0. Targets are loaded with bits [1:0] forced to 0.
- `redirect` in BOOT is ignored.
- An `imem_ack` while `imem_req`=0 is ignored.

## Timing
- All state changes occur on the rising edge of `clk`, except reset, which acts asynchronously.
- Fetch latency is 1 cycle after the edge on which `imem_ack` is sampled (`if_valid` rises on that edge).
- Peak throughput is one instruction every 2 cycles (FETCH ack, then HOLD consumed), with zero memory wait states.
- A redirect takes effect on the next edge. No instruction fetched after a redirect, from the wrong path, ever reaches `if_valid`.
- `imem_addr` and `imem_req` never change while a request is unacknowledged, except on the FETCH redirect+ack case (new request begins the next cycle).
- Reset asserted mid-request aborts the request immediately. The memory must tolerate a dropped request.

## Test plan
- Reset, then zero-wait acks, `id_ready`=1: `if_pc` reads 0, 4, 8, 12, one new value every 2 cycles, and `if_inst` matches memory at each address.
- Memory acks 3 cycles after the request: `imem_addr`=0 holds for all 3 cycles, and `if_valid` rises on the cycle after the ack.
- `id_ready`=0 for 4 cycles in HOLD: `if_inst`/`if_pc` are unchanged, `if_valid` stays 1, and `imem_req` stays 0.
- `redirect`=1 with target 32'h100 while waiting for an ack (DRAIN): the stale response is dropped, the next request is to 32'h100, and `if_pc`=32'h100 is the next valid output.
- `redirect` and `imem_ack` in the same cycle (target 32'h40): the response is discarded and `imem_addr`=32'h40 on the next cycle; a target of 32'h43 is likewise fetched at 32'h40.
- `halt` with `id_ready` at `if_pc`=8: the state enters HALT with `imem_req`=0 and `if_valid`=0 permanently. A later `redirect` has no effect, and asserting `rst` restarts the fetch at RESET_PC.
